// File: rtl/prf_write_arbiter.sv
// prf_write_arbiter
// Shares the physical register file's single write port between two
// writeback sources (src0 = ALU, src1 = memory) with round-robin priority,
// registers the granted write onto the port, and keeps one ready bit per
// physical register for the issue logic's operand queries.
//
// Ports
//   CLK, RESET                     clock, synchronous active-high reset
//   Req{0,1}Valid_IN/Addr_IN/Data_IN  writeback requests
//   Req{0,1}Ready_OUT              request accepted when its Valid is also 1
//   Alloc_IN, AllocAddr_IN         rename allocation: clears a ready bit
//   QueryAddr{A,B,C}_IN            operand registers to look up
//   Ready{A,B,C}_OUT               ready bit of each queried register
//   Write_OUT, RegWrite_OUT, DataWrite_OUT  register file write port
//   PendingCount_OUT               number of registers not ready
module prf_write_arbiter #(
    parameter int NUM_PHYS_REGS = 64,
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Req0Valid_IN,
    input  logic [LOG_PHYS-1:0] Req0Addr_IN,
    input  logic [31:0]         Req0Data_IN,
    output logic                Req0Ready_OUT,
    input  logic                Req1Valid_IN,
    input  logic [LOG_PHYS-1:0] Req1Addr_IN,
    input  logic [31:0]         Req1Data_IN,
    output logic                Req1Ready_OUT,
    input  logic                Alloc_IN,
    input  logic [LOG_PHYS-1:0] AllocAddr_IN,
    input  logic [LOG_PHYS-1:0] QueryAddrA_IN,
    input  logic [LOG_PHYS-1:0] QueryAddrB_IN,
    input  logic [LOG_PHYS-1:0] QueryAddrC_IN,
    output logic                ReadyA_OUT,
    output logic                ReadyB_OUT,
    output logic                ReadyC_OUT,
    output logic                Write_OUT,
    output logic [LOG_PHYS-1:0] RegWrite_OUT,
    output logic [31:0]         DataWrite_OUT,
    output logic [LOG_PHYS:0]   PendingCount_OUT
);

    localparam logic [LOG_PHYS:0] PEND_ONE = {{LOG_PHYS{1'b0}}, 1'b1};

    logic                     ptr_q, ptr_d;
    logic                     grant0, grant1, grant;
    logic [LOG_PHYS-1:0]      grant_addr;
    logic [31:0]              grant_data;
    logic                     write_q;
    logic [LOG_PHYS-1:0]      reg_write_q;
    logic [31:0]              data_write_q;
    logic [NUM_PHYS_REGS-1:0] ready_q, ready_d;
    logic [LOG_PHYS:0]        pending_q, pending_d;
    logic                     alloc_eff;
    logic                     pend_inc, pend_dec;

    // Readiness never looks at the requester's own valid, so a source can
    // see its ready before deciding to assert valid.
    assign Req0Ready_OUT = !(Req1Valid_IN && ptr_q);
    assign Req1Ready_OUT = !(Req0Valid_IN && !ptr_q);

    // The ready equations make these mutually exclusive.
    assign grant0     = Req0Valid_IN && Req0Ready_OUT;
    assign grant1     = Req1Valid_IN && Req1Ready_OUT;
    assign grant      = grant0 || grant1;
    assign grant_addr = grant1 ? Req1Addr_IN : Req0Addr_IN;
    assign grant_data = grant1 ? Req1Data_IN : Req0Data_IN;

    assign alloc_eff  = Alloc_IN && (AllocAddr_IN != '0);

    always_comb begin
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end
    end

    // Write sets first so a same-cycle alloc to the same register wins.
    always_comb begin
        ready_d = ready_q;
        if (write_q) begin
            ready_d[reg_write_q] = 1'b1;
        end
        if (alloc_eff) begin
            ready_d[AllocAddr_IN] = 1'b0;
        end
        ready_d[0] = 1'b1;
    end

    // Incremental zero count. A write whose register is re-allocated in the
    // same cycle leaves the bit clear, so it must not decrement.
    always_comb begin
        pend_inc  = alloc_eff && ready_q[AllocAddr_IN];
        pend_dec  = write_q && !ready_q[reg_write_q]
                    && !(alloc_eff && (AllocAddr_IN == reg_write_q));
        pending_d = pending_q;
        if (pend_inc && !pend_dec) begin
            pending_d = pending_q + PEND_ONE;
        end else if (pend_dec && !pend_inc) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q        <= 1'b0;
            write_q      <= 1'b0;
            reg_write_q  <= '0;
            data_write_q <= '0;
            ready_q      <= '1;
            pending_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            // Register 0 is granted (the source is released) but never written.
            write_q   <= grant && (grant_addr != '0);
            if (grant) begin
                reg_write_q  <= grant_addr;
                data_write_q <= grant_data;
            end
            ready_q   <= ready_d;
            pending_q <= pending_d;
        end
    end

    assign ReadyA_OUT       = ready_q[QueryAddrA_IN];
    assign ReadyB_OUT       = ready_q[QueryAddrB_IN];
    assign ReadyC_OUT       = ready_q[QueryAddrC_IN];
    assign Write_OUT        = write_q;
    assign RegWrite_OUT     = reg_write_q;
    assign DataWrite_OUT    = data_write_q;
    assign PendingCount_OUT = pending_q;

endmodule

// File: tb/tb_prf_write_arbiter.sv
// Testbench for prf_write_arbiter: a directed vector table followed by
// randomized traffic checked against a behavioural model of the register
// readiness set, the priority pointer and the write-port pipeline.
module tb_prf_write_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Req0Valid_IN, Req1Valid_IN;
    logic [5:0]  Req0Addr_IN, Req1Addr_IN;
    logic [31:0] Req0Data_IN, Req1Data_IN;
    logic        Req0Ready_OUT, Req1Ready_OUT;
    logic        Alloc_IN;
    logic [5:0]  AllocAddr_IN;
    logic [5:0]  QueryAddrA_IN, QueryAddrB_IN, QueryAddrC_IN;
    logic        ReadyA_OUT, ReadyB_OUT, ReadyC_OUT;
    logic        Write_OUT;
    logic [5:0]  RegWrite_OUT;
    logic [31:0] DataWrite_OUT;
    logic [6:0]  PendingCount_OUT;

    int checks = 0;
    int errors = 0;

    prf_write_arbiter #(.NUM_PHYS_REGS(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .Req0Valid_IN(Req0Valid_IN), .Req0Addr_IN(Req0Addr_IN),
        .Req0Data_IN(Req0Data_IN), .Req0Ready_OUT(Req0Ready_OUT),
        .Req1Valid_IN(Req1Valid_IN), .Req1Addr_IN(Req1Addr_IN),
        .Req1Data_IN(Req1Data_IN), .Req1Ready_OUT(Req1Ready_OUT),
        .Alloc_IN(Alloc_IN), .AllocAddr_IN(AllocAddr_IN),
        .QueryAddrA_IN(QueryAddrA_IN), .QueryAddrB_IN(QueryAddrB_IN),
        .QueryAddrC_IN(QueryAddrC_IN),
        .ReadyA_OUT(ReadyA_OUT), .ReadyB_OUT(ReadyB_OUT), .ReadyC_OUT(ReadyC_OUT),
        .Write_OUT(Write_OUT), .RegWrite_OUT(RegWrite_OUT),
        .DataWrite_OUT(DataWrite_OUT), .PendingCount_OUT(PendingCount_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        v0; logic [5:0] a0; logic [31:0] d0;
        logic        v1; logic [5:0] a1; logic [31:0] d1;
        logic        al; logic [5:0] aa;
        logic [5:0]  qa, qb, qc;
        logic        r0, r1;
        logic        wr; logic cwa; logic [5:0] wa; logic [31:0] wd;
        logic [6:0]  pend;
        logic        ra, rb, rc;
    } vec_t;

    // Behavioural model state
    bit          m_ready [64];
    bit          m_ptr;
    bit          m_wr;
    logic [5:0]  m_wa;
    logic [31:0] m_wd;
    bit          model_ok = 0;

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < 64; i++) if (!m_ready[i]) n++;
        return n;
    endfunction

    // Which source wins this cycle: the preferred one if both ask, else the asker.
    function automatic int m_grant(input logic v0, input logic v1);
        if (v0 && v1) return int'(m_ptr);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst,
        input logic v0, input logic [5:0] a0, input logic [31:0] d0,
        input logic v1, input logic [5:0] a1, input logic [31:0] d1,
        input logic al, input logic [5:0] aa,
        input logic [5:0] qa, input logic [5:0] qb, input logic [5:0] qc,
        input logic r0, input logic r1,
        input logic wr, input logic cwa, input logic [5:0] wa, input logic [31:0] wd,
        input logic [6:0] pend, input logic ra, input logic rb, input logic rc);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.al = al; v.aa = aa; v.qa = qa; v.qb = qb; v.qc = qc; v.r0 = r0; v.r1 = r1;
        v.wr = wr; v.cwa = cwa; v.wa = wa; v.wd = wd; v.pend = pend;
        v.ra = ra; v.rb = rb; v.rc = rc;
        return v;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, advance the
    // model, check registered outputs. Table expectations are checked when tab=1.
    task automatic step(input vec_t v, input bit tab, input int idx);
        int g;
        bit nr [64];
        RESET = v.rst;
        Req0Valid_IN = v.v0; Req0Addr_IN = v.a0; Req0Data_IN = v.d0;
        Req1Valid_IN = v.v1; Req1Addr_IN = v.a1; Req1Data_IN = v.d1;
        Alloc_IN = v.al; AllocAddr_IN = v.aa;
        QueryAddrA_IN = v.qa; QueryAddrB_IN = v.qb; QueryAddrC_IN = v.qc;
        #2;
        if (model_ok) begin
            chk("req0_ready", 32'(Req0Ready_OUT), 32'(!(v.v1 && m_ptr)));
            chk("req1_ready", 32'(Req1Ready_OUT), 32'(!(v.v0 && !m_ptr)));
            chk("readyA", 32'(ReadyA_OUT), 32'(m_ready[v.qa]));
            chk("readyB", 32'(ReadyB_OUT), 32'(m_ready[v.qb]));
            chk("readyC", 32'(ReadyC_OUT), 32'(m_ready[v.qc]));
        end
        if (tab) begin
            chk($sformatf("row%0d req0_ready", idx), 32'(Req0Ready_OUT), 32'(v.r0));
            chk($sformatf("row%0d req1_ready", idx), 32'(Req1Ready_OUT), 32'(v.r1));
        end
        @(posedge CLK);
        if (v.rst) begin
            for (int i = 0; i < 64; i++) m_ready[i] = 1'b1;
            m_ptr = 1'b0; m_wr = 1'b0; m_wa = '0; m_wd = '0;
        end else begin
            nr = m_ready;
            if (m_wr) nr[m_wa] = 1'b1;
            if (v.al && v.aa != 0) nr[v.aa] = 1'b0;
            m_ready = nr;
            g = m_grant(v.v0, v.v1);
            if (g >= 0) begin
                m_ptr = (g == 0);
                m_wa  = (g == 0) ? v.a0 : v.a1;
                m_wd  = (g == 0) ? v.d0 : v.d1;
                m_wr  = (m_wa != 0);
            end else begin
                m_wr = 1'b0;
            end
        end
        model_ok = 1;
        #1;
        chk("write", 32'(Write_OUT), 32'(m_wr));
        chk("pending", 32'(PendingCount_OUT), 32'(m_pending()));
        if (m_wr) begin
            chk("reg_write", 32'(RegWrite_OUT), 32'(m_wa));
            chk("data_write", DataWrite_OUT, m_wd);
        end
        if (tab) begin
            chk($sformatf("row%0d write", idx), 32'(Write_OUT), 32'(v.wr));
            if (v.cwa) begin
                chk($sformatf("row%0d reg_write", idx), 32'(RegWrite_OUT), 32'(v.wa));
                chk($sformatf("row%0d data_write", idx), DataWrite_OUT, v.wd);
            end
            chk($sformatf("row%0d pending", idx), 32'(PendingCount_OUT), 32'(v.pend));
            chk($sformatf("row%0d readyA", idx), 32'(ReadyA_OUT), 32'(v.ra));
            chk($sformatf("row%0d readyB", idx), 32'(ReadyB_OUT), 32'(v.rb));
            chk($sformatf("row%0d readyC", idx), 32'(ReadyC_OUT), 32'(v.rc));
        end
    endtask

    vec_t vecs[$];

    initial begin
        vec_t        rv;
        logic        sv0, sv1;
        logic [5:0]  sa0, sa1;
        logic [31:0] sd0, sd1;
        int          g;

        //                rst v0 a0 d0            v1 a1 d1        al aa  qa qb qc  r0 r1 wr cwa wa d              pend ra rb rc
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,        0, 0,  0, 5,63,  1, 1, 0, 1, 0, 0,             0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        1, 5,  5, 5, 5,  1, 1, 0, 1, 0, 0,             1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0,  5, 5, 5,  1, 0, 1, 1, 5, 32'hDEADBEEF,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0,  5, 5, 5,  1, 1, 0, 1, 5, 32'hDEADBEEF,  0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,        0, 0,  7, 9, 0,  1, 1, 0, 1, 0, 0,             0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 7, 32'h700,      1, 9, 32'h900,  0, 0,  7, 9, 0,  1, 0, 1, 1, 7, 32'h700,       0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 7, 32'h700,      1, 9, 32'h900,  0, 0,  7, 9, 0,  0, 1, 1, 1, 9, 32'h900,       0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 7, 32'h700,      1, 9, 32'h900,  0, 0,  7, 9, 0,  1, 0, 1, 1, 7, 32'h700,       0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 7, 32'h700,      1, 9, 32'h900,  0, 0,  7, 9, 0,  0, 1, 1, 1, 9, 32'h900,       0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0,  7, 9, 0,  1, 1, 0, 1, 9, 32'h900,       0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        1,12, 12,12,12,  1, 1, 0, 1, 9, 32'h900,       1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            1,12, 32'hC0C0, 0, 0, 12,12,12,  1, 1, 1, 1,12, 32'hC0C0,      1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        1,12, 12,12,12,  1, 1, 0, 1,12, 32'hC0C0,      1, 0, 0, 0));
        vecs.push_back(mk(0, 1,12, 32'h1,        0, 0, 0,        0, 0, 12,12,12,  1, 0, 1, 1,12, 32'h1,         1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0, 12,12,12,  1, 1, 0, 1,12, 32'h1,         0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            1, 0, 32'h1234, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0,             0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        1, 0,  0, 0, 0,  1, 1, 0, 0, 0, 0,             0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,        1, 5,  5, 9, 0,  1, 1, 0, 0, 0, 0,             1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 5, 32'h55,       0, 0, 0,        1, 9,  5, 9, 0,  1, 0, 0, 1, 0, 0,             0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 3, 32'h3,        1, 4, 32'h4,    0, 0,  3, 4, 0,  1, 0, 1, 1, 3, 32'h3,         0, 1, 1, 1));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b1, i);

        // Randomized traffic; sources hold their request until granted.
        sv0 = 1'b0; sv1 = 1'b0; sa0 = '0; sa1 = '0; sd0 = '0; sd1 = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!sv0 && $urandom_range(0, 1) == 1) begin
                sv0 = 1'b1; sa0 = 6'($urandom_range(0, 15)); sd0 = $urandom;
            end
            if (!sv1 && $urandom_range(0, 1) == 1) begin
                sv1 = 1'b1; sa1 = 6'($urandom_range(0, 15)); sd1 = $urandom;
            end
            rv = mk(1'b0, sv0, sa0, sd0, sv1, sa1, sd1, 1'b0, '0, '0, '0, '0,
                    0, 0, 0, 0, '0, '0, '0, 0, 0, 0);
            rv.rst = ($urandom_range(0, 99) == 0);
            rv.al  = ($urandom_range(0, 2) == 0);
            rv.aa  = ($urandom_range(0, 3) == 0) ? m_wa : 6'($urandom_range(0, 15));
            rv.qa  = ($urandom_range(0, 1) == 0) ? sa0 : 6'($urandom_range(0, 15));
            rv.qb  = ($urandom_range(0, 1) == 0) ? sa1 : 6'($urandom_range(0, 15));
            rv.qc  = 6'($urandom_range(0, 63));
            g = rv.rst ? -1 : m_grant(sv0, sv1);
            step(rv, 1'b0, n);
            if (g == 0) sv0 = 1'b0;
            if (g == 1) sv1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_write_arbiter.md
# prf_write_arbiter

Write-port arbiter and readiness scoreboard for the physical register file in the RegRead stage. Shares the file's single write port between two writeback sources (src0 = ALU, src1 = memory) using round-robin arbitration with a valid/ready handshake, registers the granted write onto the port, and keeps a per-register ready bit. Downstream issue logic queries those bits for the three source operands (A, B, C).

## Interface
- NUM_PHYS_REGS, 64, number of physical registers; LOG_PHYS = $clog2(NUM_PHYS_REGS)
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- Req0Valid_IN / Req1Valid_IN  in  1  writeback request from src0 / src1
- Req0Addr_IN / Req1Addr_IN  in  LOG_PHYS  destination physical register
- Req0Data_IN / Req1Data_IN  in  32  writeback data
- Req0Ready_OUT / Req1Ready_OUT  out  1  request accepted this cycle when ReqNValid_IN is also 1
- Alloc_IN  in  1  rename has allocated a destination; clear its ready bit
- AllocAddr_IN  in  LOG_PHYS  register being allocated
- QueryAddrA_IN / QueryAddrB_IN / QueryAddrC_IN  in  LOG_PHYS  operand registers to check
- ReadyA_OUT / ReadyB_OUT / ReadyC_OUT  out  1  ready bit of the matching query register
- Write_OUT  out  1  write enable to the register file
- RegWrite_OUT  out  LOG_PHYS  write address to the register file
- DataWrite_OUT  out  32  write data to the register file
- PendingCount_OUT  out  LOG_PHYS+1  number of registers currently not ready

## Operation
**Arbitration**
- A one-bit priority pointer `ptr` selects the preferred source. Reset value is 0.
- ReqNReady_OUT is combinational and does not depend on ReqNValid_IN:
  - Req0Ready_OUT = !(Req1Valid_IN && ptr==1)
  - Req1Ready_OUT = !(Req0Valid_IN && ptr==0)
- A grant (handshake) occurs when ReqNValid_IN && ReqNReady_OUT. At most one grant per cycle.
- On any grant, `ptr` moves to the non-granted source. With no grant, `ptr` holds.
- Source behaviour: a source holds its Valid, Addr and Data stable until it is granted.

**Write port**
- On a grant, the granted Addr/Data are registered into RegWrite_OUT/DataWrite_OUT and Write_OUT=1 for exactly one cycle.
- With no grant, Write_OUT=0 and RegWrite_OUT/DataWrite_OUT hold their previous values.
- A write to register 0 is granted but suppressed: Write_OUT stays 0. Register 0 is hardwired ready.

**Scoreboard**
- One ready bit per register. Bit 0 is constant 1.
- Alloc_IN clears bit[AllocAddr_IN] at the edge. Alloc to register 0 is ignored.
- When Write_OUT=1, bit[RegWrite_OUT] is set at the same edge the register file writes.
- Simultaneous alloc and write to the same register: the alloc wins and the bit ends at 0.
- ReadyX_OUT = bit[QueryAddrX_IN], combinational.

**PendingCount_OUT**
- Equals the count of 0 bits; it is registered and updated incrementally.
- Alloc of a currently-ready register: +1.
- Write setting a currently-not-ready register: −1.
- Alloc + write to different registers: both deltas apply.
- Alloc + write to the same register: +1 if the bit was 1, 0 if the bit was 0.
- Alloc of an already-not-ready register: no change.
- Write to an already-ready register: no change; the file is still written.
- Range is 0..NUM_PHYS_REGS−1, so no wrap is possible.

## Timing
- Reset values (edge with RESET=1):
  - Write_OUT=0, RegWrite_OUT=0, DataWrite_OUT=0
  - ptr=0, all ready bits 1, PendingCount_OUT=0
- RESET overrides any grant or alloc in that cycle. A registered write pending at reset is dropped, so Write_OUT=0 in the cycle after reset.
- Latency:
  - Grant in cycle t → Write_OUT=1 in cycle t+1.
  - Ready bit set at the end of t+1 → ReadyX_OUT=1 from cycle t+2.
- Alloc asserted in cycle t → ReadyX_OUT=0 from t+1.
- Throughput: one write per cycle. With both sources continuously valid, grants alternate 0,1,0,1…

## Test plan
- Reset: after RESET, Write_OUT=0, PendingCount_OUT=0, ReadyA/B/C_OUT=1 for query addresses 0, 5, 63.
- Alloc then write:
  - Alloc reg 5 at t → ReadyA_OUT(5)=0 and PendingCount_OUT=1 at t+1.
  - Req0 writes 0xDEADBEEF to reg 5, granted at t+2 → Write_OUT=1, RegWrite_OUT=5 at t+3.
  - ReadyA_OUT=1 and PendingCount_OUT=0 at t+4.
- Contention: both sources valid for 4 cycles from reset with addresses 7 and 9 → grant order src0, src1, src0, src1, and Write_OUT addresses 7, 9, 7, 9 one cycle later.
- Same-register collision: reg 12 pending with a write issuing while Alloc_IN targets reg 12 in the same cycle → ReadyB_OUT(12)=0 and PendingCount_OUT unchanged.
- Register 0: Req1 writes 0x1234 to reg 0 → Req1Ready_OUT=1, Write_OUT stays 0; Alloc reg 0 → ReadyC_OUT(0)=1 and PendingCount_OUT unchanged.
- Reset mid-operation: grant in cycle t with RESET=1 in t → Write_OUT=0 at t+1, all ready bits 1, ptr=0.
